ram_arbiter: RTL and testbench

Shares the single 4-entry RAM between two requesters: the button-capture path (A) and the LED-playback path (B). Each requester issues one read or write at a time over a req/gnt handshake; the arbiter serialises them round-robin, drives the RAM's read/write strobes and split addresses, and returns read data with a valid pulse. It sits between the sequencing logic and the RAM instance, and replaces direct strobe driving.

---
 rtl/ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin req/gnt arbiter sharing one small RAM between two
//            requesters (A: button capture, B: LED playback).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [7:0]        collisions
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_RDATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              win_b_q, win_b_d;
    logic              we_q, we_d;
    logic              last_b_q, last_b_d;
    logic [7:0]        coll_q, coll_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;

    // B wins when it is the only requester, or on contention when A was granted last
    logic              w_pick_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_issue;

    assign w_pick_b    = b_req & (~a_req | ~last_b_q);
    assign w_sel_we    = w_pick_b ? b_we    : a_we;
    assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;

    always_comb begin
        state_d    = state_q;
        win_b_d    = win_b_q;
        we_d       = we_q;
        last_b_d   = last_b_q;
        coll_d     = coll_q;
        ra_d       = ra_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (a_req && b_req && (coll_q != 8'hFF)) begin
                    coll_d = coll_q + 8'd1;
                end
                if (a_req || b_req) begin
                    win_b_d  = w_pick_b;
                    last_b_d = w_pick_b;
                    we_d     = w_sel_we;
                    // Address/data registers double as the held RAM-side outputs
                    if (w_sel_we) begin
                        wa_d = w_sel_addr;
                        wd_d = w_sel_wdata;
                    end else begin
                        ra_d = w_sel_addr;
                    end
                    state_d = C_ISSUE;
                end
            end
            C_ISSUE: begin
                state_d = we_q ? C_IDLE : C_RDATA;
            end
            C_RDATA: begin
                if (win_b_q) begin
                    b_rdata_d  = ram_read_data;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = ram_read_data;
                    a_rvalid_d = 1'b1;
                end
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= C_IDLE;
            win_b_q    <= 1'b0;
            we_q       <= 1'b0;
            last_b_q   <= 1'b1;
            coll_q     <= 8'd0;
            ra_q       <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_b_q    <= win_b_d;
            we_q       <= we_d;
            last_b_q   <= last_b_d;
            coll_q     <= coll_d;
            ra_q       <= ra_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign w_issue        = (state_q == C_ISSUE);
    assign a_gnt          = w_issue & ~win_b_q;
    assign b_gnt          = w_issue &  win_b_q;
    assign ram_write      = w_issue &  we_q;
    assign ram_read       = w_issue & ~we_q;
    assign ram_read_addr  = ra_q;
    assign ram_write_addr = wa_q;
    assign ram_write_data = wd_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign collisions     = coll_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter: transaction-level model with
//            an event schedule, directed scenarios and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_arbiter;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_read, ram_write;
    logic [DW-1:0] a_rdata, b_rdata, ram_write_data;
    logic [AW-1:0] ram_read_addr, ram_write_addr;
    logic [DW-1:0] ram_read_data = '0;
    logic [7:0]    collisions;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .collisions(collisions)
    );

    // Environment RAM: read data appears the cycle after the strobe
    logic [DW-1:0] ram [4] = '{default: '0};
    always @(posedge clk) begin
        if (ram_write) ram[ram_write_addr] <= ram_write_data;
        if (ram_read)  ram_read_data <= ram[ram_read_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: each accepted command schedules its visible
    // effects at fixed offsets in the future.
    typedef struct packed {
        logic ga, gb, rd, wr, va, vb;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } ev_t;

    ev_t           sched [4];
    logic [DW-1:0] mmem [4] = '{default: '0};
    int            busy;
    bit            last_b;
    logic          e_ga, e_gb, e_rd, e_wr, e_va, e_vb;
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_wd, e_ard, e_brd;
    int            e_coll;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) sched[k] = '0;
        busy = 0; last_b = 1'b1; e_coll = 0;
        e_ga = 0; e_gb = 0; e_rd = 0; e_wr = 0; e_va = 0; e_vb = 0;
        e_ra = '0; e_wa = '0; e_wd = '0; e_ard = '0; e_brd = '0;
    endtask

    // Consumes this cycle's requester inputs and advances expectations one cycle.
    task automatic model_step();
        int  coll_next;
        bit  wb, we;
        ev_t ev, rv;
        coll_next = e_coll;
        if (busy == 0 && (a_req || b_req)) begin
            if (a_req && b_req) begin
                wb = !last_b;
                coll_next = (e_coll >= 255) ? 255 : e_coll + 1;
            end else begin
                wb = b_req;
            end
            last_b = wb;
            we = wb ? b_we : a_we;
            ev = '0;
            ev.ga = !wb; ev.gb = wb;
            ev.addr = wb ? b_addr : a_addr;
            if (we) begin
                ev.wr = 1'b1;
                ev.dat = wb ? b_wdata : a_wdata;
                mmem[ev.addr] = ev.dat;
                busy = 2;
            end else begin
                ev.rd = 1'b1;
                rv = '0;
                rv.va = !wb; rv.vb = wb;
                rv.dat = mmem[ev.addr];
                sched[3] = rv;
                busy = 3;
            end
            sched[1] = ev;
        end
        for (int k = 0; k < 3; k++) sched[k] = sched[k+1];
        sched[3] = '0;
        e_ga = sched[0].ga; e_gb = sched[0].gb;
        e_rd = sched[0].rd; e_wr = sched[0].wr;
        e_va = sched[0].va; e_vb = sched[0].vb;
        if (sched[0].rd) e_ra = sched[0].addr;
        if (sched[0].wr) begin e_wa = sched[0].addr; e_wd = sched[0].dat; end
        if (sched[0].va) e_ard = sched[0].dat;
        if (sched[0].vb) e_brd = sched[0].dat;
        e_coll = coll_next;
        if (busy > 0) busy--;
    endtask

    task automatic compare_now();
        chk("a_gnt", a_gnt, e_ga);
        chk("b_gnt", b_gnt, e_gb);
        chk("ram_read", ram_read, e_rd);
        chk("ram_write", ram_write, e_wr);
        chk("a_rvalid", a_rvalid, e_va);
        chk("b_rvalid", b_rvalid, e_vb);
        chk("ram_read_addr", ram_read_addr, e_ra);
        chk("ram_write_addr", ram_write_addr, e_wa);
        chk("ram_write_data", ram_write_data, e_wd);
        chk("a_rdata", a_rdata, e_ard);
        chk("b_rdata", b_rdata, e_brd);
        chk("collisions", collisions, e_coll);
    endtask

    task automatic sample();
        @(negedge clk);
        compare_now();
    endtask

    task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req = r; a_we = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req = r; b_we = w; b_addr = ad; b_wdata = d;
    endtask

    task automatic next_cycle();
        model_step();
        sample();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, {a_gnt, b_gnt}, 0);
        chk({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
        chk({tag, "_strobes"}, {ram_read, ram_write}, 0);
        chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
        chk({tag, "_addrs"}, {ram_read_addr, ram_write_addr, ram_write_data}, 0);
        chk({tag, "_coll"}, collisions, 0);
    endtask

    bit pend_a, pend_b;

    initial begin
        int order, nrd, g1, g2, nv;

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_now();
        check_all_zero("reset");

        // A writes 0x03 to address 2
        set_a(1, 1, 2, 8'h03); next_cycle();
        chk("wr_a_gnt", a_gnt, 1);
        chk("wr_b_gnt", b_gnt, 0);
        chk("wr_strobe", ram_write, 1);
        chk("wr_addr", ram_write_addr, 2);
        chk("wr_data", ram_write_data, 8'h03);
        set_a(0, 0, 0, 0); next_cycle();

        // B reads it back
        set_b(1, 0, 2, 0); next_cycle();
        chk("rd_b_gnt", b_gnt, 1);
        chk("rd_strobe", ram_read, 1);
        chk("rd_addr", ram_read_addr, 2);
        set_b(0, 0, 0, 0); next_cycle();
        next_cycle();
        chk("rd_b_rvalid", b_rvalid, 1);
        chk("rd_b_rdata", b_rdata, 8'h03);
        chk("rd_a_rdata", a_rdata, 8'h00);

        // Eight contended writes: grants alternate starting with A
        order = 0; nrd = 0;
        for (int k = 0; k < 16; k++) begin
            set_a(1, 1, AW'($urandom), DW'($urandom));
            set_b(1, 1, AW'($urandom), DW'($urandom));
            next_cycle();
            if (k[0] == 1'b0) order = order | (int'(b_gnt) << (k / 2));
            if (ram_read) nrd++;
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); next_cycle();
        chk("alt_order", order, 32'hAA);
        chk("alt_coll", collisions, 8);
        chk("alt_no_read", nrd, 0);

        // Saturation of the collision counter
        for (int k = 0; k < 600; k++) begin
            set_a(1, 1, AW'($urandom), DW'($urandom));
            set_b(1, 1, AW'($urandom), DW'($urandom));
            next_cycle();
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); next_cycle();
        chk("sat_coll", collisions, 255);

        // Back-to-back single-requester reads of known data
        set_a(1, 1, 3, 8'hA5); next_cycle();
        set_a(1, 1, 0, 8'h5A); next_cycle();
        next_cycle();
        set_a(0, 0, 0, 0); next_cycle();
        set_a(1, 0, 3, 0); model_step();
        g1 = -1; g2 = -1; nv = 0;
        for (int k = 1; k <= 7; k++) begin
            sample();
            if (a_gnt) begin
                if (g1 < 0) g1 = k; else g2 = k;
            end
            if (a_rvalid) begin
                if (nv == 0) chk("b2b_data3", a_rdata, 8'hA5);
                else         chk("b2b_data0", a_rdata, 8'h5A);
                nv++;
            end
            if (k == 1) set_a(1, 0, 0, 0);
            else if (k == 4) set_a(0, 0, 0, 0);
            model_step();
        end
        sample();
        chk("b2b_gap", g2 - g1, 3);
        chk("b2b_nvalid", nv, 2);

        // Reset asserted during RDATA of a B read
        set_b(1, 0, 1, 0); next_cycle();
        chk("rst_b_gnt", b_gnt, 1);
        set_b(0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        compare_now();
        set_a(1, 0, 0, 0); set_b(1, 0, 1, 0); next_cycle();
        chk("rst_first_a", a_gnt, 1);
        chk("rst_no_brv", b_rvalid, 0);
        set_a(0, 0, 0, 0); next_cycle();
        next_cycle();
        set_b(0, 0, 0, 0); next_cycle();
        for (int k = 0; k < 4; k++) next_cycle();

        // Randomized traffic obeying the requester protocol
        pend_a = 0; pend_b = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!pend_a || e_ga) begin
                pend_a = ($urandom_range(0, 99) < 55);
                set_a(pend_a, 1'($urandom), AW'($urandom), DW'($urandom));
            end
            if (!pend_b || e_gb) begin
                pend_b = ($urandom_range(0, 99) < 45);
                set_b(pend_b, 1'($urandom), AW'($urandom), DW'($urandom));
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
